gpio_port_ctrl: RTL and testbench



---
 rtl/gpio_port_ctrl_if.sv | 24 ++
 rtl/gpio_port_ctrl.sv | 122 ++++++++++++
 tb/tb_gpio_port_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_port_ctrl_if.sv
// Single-cycle register bus between a software master and the GPIO port controller.
interface gpio_port_ctrl_if;
  logic        sel_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (
    output sel_i,
    output we_i,
    output addr_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  sel_i,
    input  we_i,
    input  addr_i,
    input  wdata_i,
    output rdata_o
  );
endinterface

// File: rtl/gpio_port_ctrl.sv
// Register-mapped GPIO port: pad drive and tri-state control, synchronized inputs,
// per-pin edge detection with sticky W1C status and a single level interrupt.
module gpio_port_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  gpio_port_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0] pad_in_i,
  output logic [WIDTH-1:0] pad_out_o,
  output logic [WIDTH-1:0] pad_in_not_out_o,
  output logic             irq_o
);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_DIR      = 3'd2;
  localparam logic [2:0] ADDR_IE       = 3'd3;
  localparam logic [2:0] ADDR_RISE     = 3'd4;
  localparam logic [2:0] ADDR_FALL     = 3'd5;
  localparam logic [2:0] ADDR_IS       = 3'd6;

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] is_q, is_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en, rd_en, armed;
  logic [WIDTH-1:0] wdata_w, clr, ev;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign wr_en        = bus.sel_i & bus.we_i;
  assign rd_en        = bus.sel_i & ~bus.we_i;
  assign wdata_w      = bus.wdata_i[WIDTH-1:0];
  assign unused_wdata = ^bus.wdata_i;

  // The sync/prev pipeline holds reset zeros for three edges; ignore edges until it is full.
  assign armed = (cnt_q == 2'd3);
  assign ev    = armed ? ((rise_q & sync2_q & ~prev_q) | (fall_q & ~sync2_q & prev_q))
                       : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    data_out_d = data_out_q;
    dir_d      = dir_q;
    ie_d       = ie_q;
    rise_d     = rise_q;
    fall_d     = fall_q;
    clr        = '0;
    if (wr_en) begin
      case (bus.addr_i)
        ADDR_DATA_OUT: data_out_d = wdata_w;
        ADDR_DIR:      dir_d      = wdata_w;
        ADDR_IE:       ie_d       = wdata_w;
        ADDR_RISE:     rise_d     = wdata_w;
        ADDR_FALL:     fall_d     = wdata_w;
        ADDR_IS:       clr        = wdata_w;
        default:       ;
      endcase
    end
    // A new edge on a pin beats a simultaneous software clear of the same bit.
    is_d  = (is_q & ~clr) | ev;
    cnt_d = armed ? cnt_q : cnt_q + 2'd1;
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr_i)
      ADDR_DATA_IN:  rd_val[WIDTH-1:0] = sync2_q;
      ADDR_DATA_OUT: rd_val[WIDTH-1:0] = data_out_q;
      ADDR_DIR:      rd_val[WIDTH-1:0] = dir_q;
      ADDR_IE:       rd_val[WIDTH-1:0] = ie_q;
      ADDR_RISE:     rd_val[WIDTH-1:0] = rise_q;
      ADDR_FALL:     rd_val[WIDTH-1:0] = fall_q;
      ADDR_IS:       rd_val[WIDTH-1:0] = is_q;
      default:       rd_val            = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  // NOTE: all flops, including the input synchronizer, clear on reset so the arm window starts from a known state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      dir_q      <= '0;
      ie_q       <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      is_q       <= '0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
      sync1_q    <= pad_in_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      ie_q       <= ie_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      is_q       <= is_d;
      rdata_q    <= rdata_d;
    end
  end

  assign pad_out_o        = data_out_q;
  assign pad_in_not_out_o = ~dir_q;
  assign irq_o            = |(is_q & ie_q);
  assign bus.rdata_o      = rdata_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a register-level model.
module tb_gpio_port_ctrl;
  localparam int          WIDTH = 16;
  localparam logic [31:0] MASK  = 32'h0000_FFFF;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [WIDTH-1:0] pad_in_i;
  logic [WIDTH-1:0] pad_out_o;
  logic [WIDTH-1:0] pad_in_not_out_o;
  logic             irq_o;

  gpio_port_ctrl_if bus_if ();

  gpio_port_ctrl #(.WIDTH(WIDTH)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .bus              (bus_if),
    .pad_in_i         (pad_in_i),
    .pad_out_o        (pad_out_o),
    .pad_in_not_out_o (pad_in_not_out_o),
    .irq_o            (irq_o)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the register file as software sees it, plus a record of the
  // last three pad samples taken at clock edges and the number of edges since reset.
  logic [31:0]      m_reg [0:7];
  logic [WIDTH-1:0] m_samples [0:2];
  int               m_edges;
  logic [31:0]      m_rdata;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      for (int i = 0; i < 3; i++) m_samples[i] = '0;
      m_edges = 0;
      m_rdata = '0;
    end else begin
      logic [WIDTH-1:0] seen_now, seen_before;
      logic [31:0]      events, clear;
      seen_now    = m_samples[1];
      seen_before = m_samples[2];
      events      = '0;
      clear       = '0;
      if (m_edges >= 3) begin
        for (int p = 0; p < WIDTH; p++) begin
          if (seen_now[p] && !seen_before[p] && m_reg[4][p]) events[p] = 1'b1;
          if (!seen_now[p] && seen_before[p] && m_reg[5][p]) events[p] = 1'b1;
        end
      end
      if (bus_if.sel_i && !bus_if.we_i) begin
        if (bus_if.addr_i == 3'd0)      m_rdata = {16'h0, seen_now};
        else if (bus_if.addr_i == 3'd7) m_rdata = '0;
        else                            m_rdata = m_reg[bus_if.addr_i];
      end
      if (bus_if.sel_i && bus_if.we_i) begin
        if (bus_if.addr_i >= 3'd1 && bus_if.addr_i <= 3'd5)
          m_reg[bus_if.addr_i] = bus_if.wdata_i & MASK;
        else if (bus_if.addr_i == 3'd6)
          clear = bus_if.wdata_i & MASK;
      end
      m_reg[6]     = (m_reg[6] & ~clear) | events;
      m_samples[2] = m_samples[1];
      m_samples[1] = m_samples[0];
      m_samples[0] = pad_in_i;
      if (m_edges < 3) m_edges++;
    end
  end

  bit cmp_en = 1'b0;

  always begin
    @(posedge HCLK);
    #2;
    if (cmp_en) begin
      check("pad_out",  {16'h0, pad_out_o},        m_reg[1] & MASK);
      check("pad_tri",  {16'h0, pad_in_not_out_o}, ~m_reg[2] & MASK);
      check("rdata",    bus_if.rdata_o,            m_rdata);
      check("irq",      {31'h0, irq_o},            {31'h0, |(m_reg[6] & m_reg[3])});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus_if.sel_i   = 1'b1;
    bus_if.we_i    = 1'b1;
    bus_if.addr_i  = addr;
    bus_if.wdata_i = data;
    @(negedge HCLK);
    bus_if.sel_i   = 1'b0;
    bus_if.we_i    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus_if.sel_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = addr;
    @(negedge HCLK);
    bus_if.sel_i  = 1'b0;
    data          = bus_if.rdata_o;
  endtask

  initial begin
    logic [31:0] rd;
    HRESETn        = 1'b0;
    pad_in_i       = '0;
    bus_if.sel_i   = 1'b0;
    bus_if.we_i    = 1'b0;
    bus_if.addr_i  = '0;
    bus_if.wdata_i = '0;
    idle(3);
    cmp_en  = 1'b1;
    HRESETn = 1'b1;

    check("rst_pad_tri", {16'h0, pad_in_not_out_o}, 32'h0000_FFFF);
    check("rst_pad_out", {16'h0, pad_out_o},        32'h0);
    check("rst_irq",     {31'h0, irq_o},            32'h0);
    check("rst_rdata",   bus_if.rdata_o,            32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], rd);
      check($sformatf("rst_read_%0d", a), rd, 32'h0);
    end

    // Pads already high through reset release must not register as edges.
    pad_in_i = 16'hFFFF;
    HRESETn  = 1'b0;
    idle(1);
    HRESETn  = 1'b1;
    bus_write(3'd4, 32'hFFFF);
    bus_write(3'd5, 32'hFFFF);
    idle(10);
    bus_read(3'd6, rd);
    check("arm_is", rd, 32'h0);
    bus_read(3'd0, rd);
    check("arm_data_in", rd, 32'h0000_FFFF);

    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h0);
    pad_in_i = 16'h0000;
    idle(5);
    bus_write(3'd6, 32'hFFFF);

    bus_write(3'd2, 32'h0000_00FF);
    check("drive_tri", {16'h0, pad_in_not_out_o}, 32'h0000_FF00);
    bus_write(3'd1, 32'hFFFF_A5A5);
    check("drive_out", {16'h0, pad_out_o}, 32'h0000_A5A5);
    bus_read(3'd2, rd);
    check("drive_rd_dir", rd, 32'h0000_00FF);
    bus_read(3'd1, rd);
    check("drive_rd_out", rd, 32'h0000_A5A5);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd7, rd);
    check("rsvd_rd", rd, 32'h0);

    bus_write(3'd4, 32'h1);
    bus_write(3'd3, 32'h1);
    pad_in_i = 16'h0001;
    idle(1);
    check("rise_irq_n", {31'h0, irq_o}, 32'h0);
    idle(1);
    check("rise_irq_n1", {31'h0, irq_o}, 32'h0);
    bus_read(3'd0, rd);
    check("rise_data_in", rd, 32'h1);
    check("rise_irq_n2", {31'h0, irq_o}, 32'h1);
    bus_read(3'd6, rd);
    check("rise_is", rd, 32'h1);
    bus_write(3'd6, 32'h1);
    check("rise_clr_irq", {31'h0, irq_o}, 32'h0);

    bus_write(3'd4, 32'h0);
    bus_write(3'd3, 32'h8);
    bus_write(3'd5, 32'h8);
    pad_in_i = 16'h0009;
    idle(4);
    pad_in_i = 16'h0001;
    idle(2);
    bus_write(3'd6, 32'h8);
    check("setwin_irq", {31'h0, irq_o}, 32'h1);
    bus_read(3'd6, rd);
    check("setwin_is", rd, 32'h8);

    bus_write(3'd3, 32'h0);
    bus_write(3'd6, 32'hFFFF);
    bus_write(3'd5, 32'h10);
    pad_in_i = 16'h0011;
    idle(4);
    pad_in_i = 16'h0001;
    idle(4);
    bus_read(3'd6, rd);
    check("mask_is", rd, 32'h10);
    check("mask_irq_off", {31'h0, irq_o}, 32'h0);
    bus_write(3'd3, 32'h10);
    check("mask_irq_on", {31'h0, irq_o}, 32'h1);

    for (int c = 0; c < 4000; c++) begin
      HRESETn = ($urandom_range(0, 399) != 0);
      pad_in_i = pad_in_i ^ WIDTH'($urandom & $urandom & $urandom);
      bus_if.sel_i   = ($urandom_range(0, 2) != 0);
      bus_if.we_i    = $urandom_range(0, 1) == 1;
      bus_if.addr_i  = 3'($urandom_range(0, 7));
      bus_if.wdata_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      @(negedge HCLK);
    end
    HRESETn      = 1'b1;
    bus_if.sel_i = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
